apb_completer: RTL

APB_COMPLETER -- requirements
Module: apb_completer

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_completer_mem.sv | 36 +++
 rtl/apb_completer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer types and constants: FSM state encoding, ID location, bus width defaults.
`ifndef AW
`define AW 8
`endif
`ifndef DW
`define DW 8
`endif

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int         APB_AW           = `AW;
  localparam int         APB_DW           = `DW;
  localparam int         ID_ADDR          = 0;
  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/apb_completer_mem.sv
// DEPTH x DW register storage: one synchronous write port, one combinational read port,
// whole array cleared by the asynchronous reset.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int AW    = APB_AW,
  parameter int DW    = APB_DW,
  parameter int DEPTH = 64
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // Out-of-range reads return 0 so the top never sees an aliased location.
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/apb_completer.sv
// APB completer: FSM, wait-state counter, address decode and error response around a
// flop-based storage array; pready/pslverr/prdata are all registered.
//
//   state  | meaning
//   IDLE   | no transfer; a setup phase (psel & !penable) is captured here
//   SETUP  | transfer captured, first access cycle, wait counter loaded
//   ACCESS | further access cycles while the wait counter runs down
module apb_completer
  import apb_pkg::*;
#(
  parameter int            AW          = APB_AW,
  parameter int            DW          = APB_DW,
  parameter int            DEPTH       = 64,
  parameter int            WAIT_CYCLES = 1,
  parameter logic [DW-1:0] ID_VALUE    = DW'(ID_VALUE_DEFAULT)
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  apb_state_e    state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [DW-1:0] wdata_q;

  logic [AW-1:0] xfer_addr;
  logic          xfer_write;
  logic          is_id;
  logic          in_range;
  logic          xfer_err;
  logic [DW-1:0] xfer_rdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;

  // The response is computed on the edge that starts the pready cycle; for a
  // zero-wait transfer that is the capture edge itself, so decode the live bus.
  always_comb begin
    xfer_addr  = (state == IDLE) ? paddr : addr_q;
    xfer_write = (state == IDLE) ? pwrite : write_q;
    is_id      = (xfer_addr == AW'(ID_ADDR));
    in_range   = (int'(xfer_addr) < DEPTH);
    xfer_err   = !in_range || (is_id && xfer_write);
    xfer_rdata = '0;
    if (!xfer_write && in_range) begin
      xfer_rdata = is_id ? ID_VALUE : mem_rdata;
    end
  end

  // Storage commits on the edge closing the pready cycle of an error-free write.
  assign mem_we = pready && write_q && !pslverr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state    <= SETUP;
            addr_q   <= paddr;
            write_q  <= pwrite;
            wdata_q  <= pwdata;
            wait_cnt <= WAIT_LOAD;
            if (WAIT_LOAD == 4'd0) begin
              pready  <= 1'b1;
              pslverr <= xfer_err;
              prdata  <= xfer_rdata;
            end
          end
        end
        SETUP, ACCESS: begin
          if (pready || !psel) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            state    <= ACCESS;
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= xfer_err;
              prdata  <= xfer_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_completer_mem #(
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_mem (
    .pclk   (pclk),
    .presetn(presetn),
    .we     (mem_we),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .raddr  (xfer_addr),
    .rdata  (mem_rdata)
  );

endmodule
